// File: rtl/cmd_pkg.sv
// Shared command-path definitions: FSM state encoding, command bytes and framing characters.
package cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StHdr  = 3'd1;
  localparam state_t StCmd  = 3'd2;
  localparam state_t StData = 3'd3;
  localparam state_t StCsum = 3'd4;
  localparam state_t StCr   = 3'd5;
  localparam state_t StLf   = 3'd6;

  localparam logic [7:0] CMD_DUTY = 8'h44;  // "D"
  localparam logic [7:0] CMD_FREQ = 8'h46;  // "F"
  localparam logic [7:0] CMD_EN   = 8'h45;  // "E"

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic logic [7:0] hdr_byte(input logic [7:0] cmd, input logic [7:0] ack,
                                          input logic [7:0] nak);
    return ((cmd == CMD_DUTY) || (cmd == CMD_FREQ) || (cmd == CMD_EN)) ? ack : nak;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and a registered occupancy count.
module sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_responder.sv
// Queues command/value pairs and serialises each as an ACK/NAK frame toward the UART TX.
// Define CMD_RESPONDER_CRLF_EN to append CR, LF to every frame.
module cmd_responder
  import cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  ACK_BYTE   = 8'h41,
  parameter logic [7:0]  NAK_BYTE   = 8'h4E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_cmd_i,
  input  logic [7:0] req_data_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic [7:0] frames_sent_o
);

  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [15:0] fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  state_t     state_q, state_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] hdr_q, hdr_d, cmd_q, cmd_d, data_q, data_d;
  logic [7:0] frames_q, frames_d;
  logic [7:0] hdr_next;
  logic       xfer, start, frame_done;

  assign fifo_push = req_valid_i && !fifo_full;

  sync_fifo #(
    .Width (16),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({req_cmd_i, req_data_i}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign xfer = tx_valid_q && tx_ready_i;

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    hdr_d      = hdr_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    frames_d   = frames_q;
    fifo_pop   = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    hdr_next   = hdr_byte(fifo_rdata[15:8], ACK_BYTE, NAK_BYTE);

    case (state_q)
      StIdle: start = !fifo_empty;
      StHdr: if (xfer) begin
        state_d   = StCmd;
        tx_data_d = cmd_q;
      end
      StCmd: if (xfer) begin
        state_d   = StData;
        tx_data_d = data_q;
      end
      StData: if (xfer) begin
        state_d   = StCsum;
        tx_data_d = hdr_q ^ cmd_q ^ data_q;
      end
`ifdef CMD_RESPONDER_CRLF_EN
      StCsum: if (xfer) begin
        state_d   = StCr;
        tx_data_d = CHAR_CR;
      end
      StCr: if (xfer) begin
        state_d   = StLf;
        tx_data_d = CHAR_LF;
      end
      StLf: frame_done = xfer;
`else
      StCsum: frame_done = xfer;
`endif
      default: begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
      end
    endcase

    if (frame_done) begin
      frames_d = frames_q + 8'd1;
      if (fifo_empty) begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
      end else begin
        start = 1'b1;
      end
    end

    // Pop and present the header in one edge so back-to-back frames have no gap.
    if (start) begin
      fifo_pop   = 1'b1;
      hdr_d      = hdr_next;
      cmd_d      = fifo_rdata[15:8];
      data_d     = fifo_rdata[7:0];
      tx_data_d  = hdr_next;
      tx_valid_d = 1'b1;
      state_d    = StHdr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      hdr_q      <= 8'h00;
      cmd_q      <= 8'h00;
      data_q     <= 8'h00;
      frames_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      hdr_q      <= hdr_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      frames_q   <= frames_d;
    end
  end

  assign req_ready_o   = !fifo_full;
  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign frames_sent_o = frames_q;
  assign busy_o        = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_cmd_responder.sv
// Directed self-checking bench for cmd_responder with hand-computed frame bytes.
module tb_cmd_responder;

`ifdef CMD_RESPONDER_CRLF_EN
  localparam int FL = 6;
`else
  localparam int FL = 4;
`endif

  logic       clk, rst;
  logic       req_valid, req_ready, tx_valid, tx_ready, busy;
  logic [7:0] req_cmd, req_data, tx_data, frames_sent;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_frames;

  cmd_responder dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_cmd_i     (req_cmd),
    .req_data_i    (req_data),
    .tx_valid_o    (tx_valid),
    .tx_data_o     (tx_data),
    .tx_ready_i    (tx_ready),
    .busy_o        (busy),
    .frames_sent_o (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle from a negedge to the next; drop req_valid once it has been accepted.
  task automatic step();
    logic acc;
    acc = req_valid && req_ready;
    @(posedge clk);
    @(negedge clk);
    if (acc) req_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] d);
    req_cmd   = c;
    req_data  = d;
    req_valid = 1'b1;
    for (int i = 0; i < 64 && req_valid; i++) step();
    chk("push_accept", {7'd0, req_valid}, 8'h00);
  endtask

  // Expects a frame on consecutive cycles with tx_ready held high; exp is hdr,cmd,data,csum.
  task automatic frame_strict(input string tag, input logic [31:0] exp);
    logic [7:0] b;
    for (int i = 0; i < FL; i++) begin
      if (i < 4) b = exp[31-8*i -: 8];
      else if (i == 4) b = 8'h0D;
      else b = 8'h0A;
      if (i == FL - 1) chk({tag, "_frames_before_last"}, frames_sent, exp_frames);
      chk({tag, "_valid"}, {7'd0, tx_valid}, 8'h01);
      chk({tag, "_byte"}, tx_data, b);
      step();
    end
    exp_frames = exp_frames + 8'd1;
    chk({tag, "_frames"}, frames_sent, exp_frames);
  endtask

  task automatic byte_bp(input string tag, input logic [7:0] b);
    bit done = 0;
    bit seen = 0;
    for (int it = 0; it < 64 && !done; it++) begin
      tx_ready = (it >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
      if (seen) chk({tag, "_hold_valid"}, {7'd0, tx_valid}, 8'h01);
      if (tx_valid) begin
        seen = 1;
        chk({tag, "_stable"}, tx_data, b);
        if (tx_ready) done = 1;
      end
      step();
    end
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL %s_timeout: observed no transfer expected transfer", tag);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_cmd = 8'h00;
    req_data = 8'h00;
    tx_ready = 1'b1;
    exp_frames = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_frames", frames_sent, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_req_ready", {7'd0, req_ready}, 8'h01);
    rst = 1'b0;
    step();

    // Single recognised request and first-byte latency.
    push(8'h44, 8'h80);
    chk("lat_pre", {7'd0, tx_valid}, 8'h00);
    chk("lat_busy", {7'd0, busy}, 8'h01);
    step();
    frame_strict("single", 32'h41448085);
    chk("single_idle_valid", {7'd0, tx_valid}, 8'h00);
    chk("single_busy", {7'd0, busy}, 8'h00);

    // Unrecognised command.
    push(8'h58, 8'h05);
    step();
    frame_strict("nak", 32'h4E580513);
    chk("nak_busy", {7'd0, busy}, 8'h00);

    // Enable command (adds CR/LF when the feature is built in).
    push(8'h45, 8'h01);
    step();
    frame_strict("en", 32'h41450105);

    // Random backpressure.
    push(8'h46, 8'h10);
    byte_bp("bp_hdr", 8'h41);
    byte_bp("bp_cmd", 8'h46);
    byte_bp("bp_data", 8'h10);
    byte_bp("bp_csum", 8'h17);
`ifdef CMD_RESPONDER_CRLF_EN
    byte_bp("bp_cr", 8'h0D);
    byte_bp("bp_lf", 8'h0A);
`endif
    tx_ready = 1'b1;
    exp_frames = exp_frames + 8'd1;
    chk("bp_frames", frames_sent, exp_frames);
    chk("bp_busy", {7'd0, busy}, 8'h00);

    // Queue full: one frame stalls in HDR, four more fill the queue, a sixth is held.
    tx_ready = 1'b0;
    push(8'h44, 8'h01);
    push(8'h46, 8'h02);
    push(8'h45, 8'h03);
    push(8'h58, 8'h04);
    push(8'h41, 8'h05);
    chk("full_req_ready", {7'd0, req_ready}, 8'h00);
    req_cmd = 8'h64;
    req_data = 8'h06;
    req_valid = 1'b1;
    step();
    step();
    step();
    chk("full_held", {7'd0, req_valid}, 8'h01);
    chk("full_req_ready2", {7'd0, req_ready}, 8'h00);
    chk("full_stall_valid", {7'd0, tx_valid}, 8'h01);
    chk("full_stall_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    frame_strict("q1", 32'h41440104);
    frame_strict("q2", 32'h41460205);
    frame_strict("q3", 32'h41450307);
    frame_strict("q4", 32'h4E580412);
    frame_strict("q5", 32'h4E41050A);
    frame_strict("q6", 32'h4E64062C);
    chk("q_after_valid", {7'd0, tx_valid}, 8'h00);
    chk("q_after_busy", {7'd0, busy}, 8'h00);

    // Reset during the DATA byte with another request queued.
    push(8'h44, 8'h22);
    step();
    chk("mid_hdr", tx_data, 8'h41);
    step();
    chk("mid_cmd", tx_data, 8'h44);
    step();
    chk("mid_data", tx_data, 8'h22);
    tx_ready = 1'b0;
    push(8'h45, 8'h33);
    chk("mid_data_stable", tx_data, 8'h22);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {7'd0, tx_valid}, 8'h00);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_frames", frames_sent, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    chk("mid_rst_ready", {7'd0, req_ready}, 8'h01);
    exp_frames = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    step();
    step();
    chk("post_rst_quiet", {7'd0, tx_valid}, 8'h00);
    push(8'h46, 8'h10);
    step();
    frame_strict("post_rst", 32'h41461017);

    // frames_sent wraps 255 -> 0.
    for (int i = 0; i < 254; i++) begin
      push(8'h44, 8'(i));
      wait_idle();
    end
    chk("wrap_255", frames_sent, 8'hFF);
    push(8'h44, 8'h00);
    wait_idle();
    chk("wrap_0", frames_sent, 8'h00);
    chk("wrap_busy", {7'd0, busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
